// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    // Width of the starvation/wait counters
    localparam int unsigned STARVE_W = 4;

    // Default bound on consecutive blocked cycles before a forced handover
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Memory owner; also the arbiter state encoding
    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating blocked-cycle counter with clear priority and a bound flag.
// sat_o counts the current cycle: it is high when the count including this
// cycle's increment has reached MAX, so a handover can happen in the same
// cycle the bound is hit.
module dmem_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned W   = STARVE_W,
    parameter int unsigned MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] PRE_V = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX_V) || (inc_i && (cnt_q == PRE_V));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage and a
// DMA/debug loader, with bounded starvation in both directions.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    owner_e        owner_q;
    owner_e        owner_d;
    logic          rvalid_q;
    logic          rvalid_d;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    logic          starve_inc;
    logic          starve_clr;
    logic          starve_sat;
    logic          wait_inc;
    logic          wait_clr;
    logic          wait_sat;
    logic          we_c;
    logic          rd_beat_c;

    // DMA blocked-by-CPU counter
    dmem_starve_counter #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    // CPU stalled-by-DMA counter
    dmem_starve_counter #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (wait_inc),
        .clr_i (wait_clr),
        .sat_o (wait_sat)
    );

    // Owner next-state, memory routing and counter control
    always_comb begin
        owner_d    = owner_q;
        mem_a      = cpu_addr;
        mem_wd     = cpu_wdata;
        we_c       = cpu_req & cpu_we;
        cpu_stall  = 1'b0;
        dma_gnt    = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b1;
        wait_inc   = 1'b0;
        wait_clr   = 1'b1;
        rd_beat_c  = 1'b0;
        case (owner_q)
            OWN_CPU: begin
                starve_inc = dma_req & cpu_req;
                starve_clr = ~dma_req;
                if (dma_req && (!cpu_req || starve_sat)) begin
                    owner_d    = OWN_DMA;
                    starve_clr = 1'b1;
                end
            end
            OWN_DMA: begin
                mem_a     = dma_addr;
                mem_wd    = dma_wdata;
                we_c      = dma_req & dma_we;
                dma_gnt   = 1'b1;
                cpu_stall = cpu_req;
                wait_inc  = cpu_req;
                wait_clr  = ~cpu_req;
                rd_beat_c = dma_req & ~dma_we;
                if ((dma_req && dma_last) || !dma_req || (cpu_req && wait_sat)) begin
                    owner_d  = OWN_CPU;
                    wait_clr = 1'b1;
                end
            end
            default: begin
                owner_d = OWN_CPU;
            end
        endcase
    end

    // Capture DMA read data on accepted read beats, otherwise hold
    always_comb begin
        rvalid_d = rd_beat_c;
        rdata_d  = rdata_q;
        if (rd_beat_c) begin
            rdata_d = mem_rd;
        end
    end

    // Owner and DMA read-return registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= OWN_CPU;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Reset suppresses any write immediately, including mid-burst
    assign mem_we     = rst & we_c;
    assign cpu_rdata  = mem_rd;
    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural owner model
// and a reference copy of the data memory.
module tb_dmem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_a, mem_wd, mem_rd;
    logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;

    int total = 0;
    int bad   = 0;

    // Memory behind the arbiter (64 words, combinational read)
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];

    // Model state
    int          m_own;     // 0 = CPU owns, 1 = DMA owns
    int          m_starve;  // DMA blocked cycles so far
    int          m_wait;    // CPU stalled cycles so far
    logic        m_rv;
    logic [31:0] m_rd;
    logic        e_gnt, e_stall, e_we;
    logic [31:0] e_a, e_wd;

    dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_last   (dma_last),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    function automatic logic [31:0] waddr(int unsigned i);
        return {24'h0, 6'(i), 2'b00};
    endfunction

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_last = 0;
    endtask

    task automatic model_reset();
        m_own = 0; m_starve = 0; m_wait = 0; m_rv = 0; m_rd = '0;
    endtask

    // Expected routing for the current owner and inputs
    task automatic predict();
        if (m_own == 0) begin
            e_gnt = 0; e_stall = 0; e_we = cpu_req & cpu_we;
            e_a = cpu_addr; e_wd = cpu_wdata;
        end else begin
            e_gnt = 1; e_stall = cpu_req; e_we = dma_req & dma_we;
            e_a = dma_addr; e_wd = dma_wdata;
        end
    endtask

    // Advance one clock and update the model from the ownership rules
    task automatic tick();
        int n_own, n_st, n_wt, cnow;
        logic n_rv;
        logic [31:0] n_rd;
        predict();
        n_own = m_own; n_st = 0; n_wt = 0; n_rv = 0; n_rd = m_rd;
        if (m_own == 0) begin
            cnow = (dma_req && cpu_req) ? m_starve + 1 : 0;
            if (dma_req && (!cpu_req || cnow >= SMAX)) n_own = 1;
            else n_st = cnow;
        end else begin
            cnow = cpu_req ? m_wait + 1 : 0;
            if (dma_req && !dma_we) begin
                n_rv = 1; n_rd = ref_mem[dma_addr[7:2]];
            end
            if (!dma_req || dma_last || (cpu_req && cnow >= SMAX)) n_own = 0;
            else n_wt = cnow;
        end
        if (e_we) ref_mem[e_a[7:2]] = e_wd;
        @(posedge clk);
        #1;
        m_own = n_own; m_starve = n_st; m_wait = n_wt; m_rv = n_rv; m_rd = n_rd;
    endtask

    task automatic test_reset();
        rst = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
            dma_req = 1'($urandom); dma_we = 1'($urandom); dma_addr = $urandom; dma_wdata = $urandom;
            dma_last = 1'($urandom);
            #1;
            total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b exp 0", dma_gnt); end
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b exp 0", cpu_stall); end
            total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b exp 0", dma_rvalid); end
            total++; if (dma_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", dma_rdata); end
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b exp 0", mem_we); end
            @(posedge clk);
            #1;
        end
        idle();
        rst = 1;
        cpu_req = 1; cpu_addr = 32'h8;
        #1;
        total++; if (mem_a !== 32'h8 || dma_gnt !== 1'b0) begin
            bad++; $display("FAIL reset_owner: mem_a=%h gnt=%b exp mem_a=8 gnt=0", mem_a, dma_gnt);
        end
        tick();
    endtask

    // Initialise every word through the CPU port
    task automatic test_cpu_fill();
        for (int i = 0; i < 64; i++) begin
            idle();
            cpu_req = 1; cpu_we = 1; cpu_addr = waddr(i); cpu_wdata = $urandom;
            #1;
            total++; if (mem_we !== 1'b1 || mem_a !== waddr(i) || cpu_stall !== 1'b0) begin
                bad++; $display("FAIL fill_%0d: we=%b a=%h stall=%b exp we=1 a=%h stall=0", i, mem_we, mem_a, cpu_stall, waddr(i));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_dma_write();
        idle();
        dma_req = 1; dma_we = 1; dma_addr = 32'h10; dma_wdata = 32'hA1;
        #1;
        total++; if (dma_gnt !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL dmaw_first: gnt=%b we=%b exp 0 0", dma_gnt, mem_we);
        end
        tick();
        for (int b = 0; b < 3; b++) begin
            dma_addr = 32'h10 + 32'(4 * b); dma_wdata = 32'hA1 + 32'(b); dma_last = (b == 2);
            #1;
            total++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_a !== dma_addr) begin
                bad++; $display("FAIL dmaw_beat%0d: gnt=%b we=%b a=%h exp 1 1 %h", b, dma_gnt, mem_we, mem_a, dma_addr);
            end
            tick();
        end
        idle();
        #1;
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL dmaw_return: gnt=%b exp 0", dma_gnt); end
        for (int b = 0; b < 3; b++) begin
            total++; if (mem[4 + b] !== 32'hA1 + 32'(b)) begin
                bad++; $display("FAIL dmaw_mem%0d: got %h exp %h", b, mem[4 + b], 32'hA1 + 32'(b));
            end
        end
    endtask

    task automatic test_contention();
        for (int c = 0; c < 5; c++) begin
            cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = (c < 4) ? 32'h1000 + 32'(c) : 32'hBAD;
            dma_req = 1; dma_we = 1; dma_addr = 32'h34; dma_wdata = 32'h2222; dma_last = (c == 4);
            #1;
            if (c < 4) begin
                total++; if (dma_gnt !== 1'b0 || mem_we !== 1'b1 || mem_a !== 32'h30) begin
                    bad++; $display("FAIL cont_cpu%0d: gnt=%b we=%b a=%h exp 0 1 30", c, dma_gnt, mem_we, mem_a);
                end
            end else begin
                total++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_a !== 32'h34) begin
                    bad++; $display("FAIL cont_dma: gnt=%b stall=%b a=%h exp 1 1 34", dma_gnt, cpu_stall, mem_a);
                end
            end
            tick();
        end
        cpu_we = 0; dma_req = 0; dma_last = 0;
        #1;
        total++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL cont_back: gnt=%b stall=%b exp 0 0", dma_gnt, cpu_stall);
        end
        total++; if (mem[12] !== 32'h1003 || mem[13] !== 32'h2222) begin
            bad++; $display("FAIL cont_mem: m30=%h m34=%h exp 1003 2222", mem[12], mem[13]);
        end
        tick();
        idle();
    endtask

    task automatic test_preempt();
        idle();
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h70;
        #1;
        tick();
        for (int k = 0; k < 4; k++) begin
            cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'hC0DE0000 + 32'(k);
            dma_addr = 32'h40 + 32'(4 * k); dma_wdata = 32'h70 + 32'(k);
            #1;
            total++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b1 || mem_a !== dma_addr) begin
                bad++; $display("FAIL pre_stall%0d: gnt=%b stall=%b we=%b a=%h exp 1 1 1 %h", k, dma_gnt, cpu_stall, mem_we, mem_a, dma_addr);
            end
            tick();
        end
        dma_req = 0; cpu_wdata = 32'hC0DE0009;
        #1;
        total++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_a !== 32'h50) begin
            bad++; $display("FAIL pre_return: gnt=%b stall=%b a=%h exp 0 0 50", dma_gnt, cpu_stall, mem_a);
        end
        tick();
        total++; if (mem[19] !== 32'h73 || mem[20] !== 32'hC0DE0009) begin
            bad++; $display("FAIL pre_mem: m4c=%h m50=%h exp 73 c0de0009", mem[19], mem[20]);
        end
        idle();
    endtask

    task automatic test_dma_read();
        idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hDEADBEEF;
        #1;
        tick();
        idle();
        dma_req = 1; dma_addr = 32'h20;
        #1;
        tick();
        #1;
        total++; if (dma_gnt !== 1'b1 || dma_rvalid !== 1'b0) begin
            bad++; $display("FAIL rd_beat1: gnt=%b rvalid=%b exp 1 0", dma_gnt, dma_rvalid);
        end
        tick();
        dma_addr = 32'h10; dma_last = 1;
        #1;
        total++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_first: rvalid=%b rdata=%h exp 1 deadbeef", dma_rvalid, dma_rdata);
        end
        tick();
        idle();
        #1;
        total++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hA1 || dma_gnt !== 1'b0) begin
            bad++; $display("FAIL rd_second: rvalid=%b rdata=%h gnt=%b exp 1 a1 0", dma_rvalid, dma_rdata, dma_gnt);
        end
        tick();
        total++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'hA1) begin
            bad++; $display("FAIL rd_hold: rvalid=%b rdata=%h exp 0 a1", dma_rvalid, dma_rdata);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] pre;
        idle();
        dma_req = 1; dma_we = 1; dma_addr = 32'h60; dma_wdata = 32'h55550000;
        #1;
        tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h64; cpu_wdata = 32'h1234;
        #1;
        total++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL ar_pre: gnt=%b stall=%b we=%b exp 1 1 1", dma_gnt, cpu_stall, mem_we);
        end
        pre = ref_mem[24];
        rst = 0;
        #1;
        total++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL ar_drop: gnt=%b stall=%b we=%b exp 0 0 0", dma_gnt, cpu_stall, mem_we);
        end
        @(posedge clk);
        #1;
        total++; if (mem[24] !== pre) begin
            bad++; $display("FAIL ar_nowrite: got %h exp %h", mem[24], pre);
        end
        idle();
        rst = 1;
        model_reset();
        cpu_req = 1; cpu_addr = 32'h64;
        #1;
        total++; if (dma_gnt !== 1'b0 || mem_a !== 32'h64 || dma_rdata !== 32'h0) begin
            bad++; $display("FAIL ar_after: gnt=%b a=%h rdata=%h exp 0 64 0", dma_gnt, mem_a, dma_rdata);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        int run = 0;
        for (int n = 0; n < 3000; n++) begin
            cpu_req = ($urandom_range(3) != 0); cpu_we = 1'($urandom);
            cpu_addr = waddr($urandom_range(63)); cpu_wdata = $urandom;
            dma_req = ($urandom_range(9) < 8); dma_we = 1'($urandom);
            dma_addr = waddr($urandom_range(63)); dma_wdata = $urandom;
            dma_last = ($urandom_range(9) == 0);
            #1;
            predict();
            total++; if (dma_gnt !== e_gnt || cpu_stall !== e_stall || mem_we !== e_we) begin
                bad++; $display("FAIL rnd_ctl@%0d: gnt=%b stall=%b we=%b exp %b %b %b", n, dma_gnt, cpu_stall, mem_we, e_gnt, e_stall, e_we);
            end
            total++; if (mem_a !== e_a || (e_we && mem_wd !== e_wd)) begin
                bad++; $display("FAIL rnd_bus@%0d: a=%h wd=%h exp %h %h", n, mem_a, mem_wd, e_a, e_wd);
            end
            total++; if (dma_rvalid !== m_rv || dma_rdata !== m_rd) begin
                bad++; $display("FAIL rnd_rd@%0d: rvalid=%b rdata=%h exp %b %h", n, dma_rvalid, dma_rdata, m_rv, m_rd);
            end
            if (!e_stall) begin
                total++; if (cpu_rdata !== ref_mem[e_a[7:2]]) begin
                    bad++; $display("FAIL rnd_cpurd@%0d: got %h exp %h", n, cpu_rdata, ref_mem[e_a[7:2]]);
                end
            end
            run = cpu_stall ? run + 1 : 0;
            total++; if (run > SMAX) begin
                bad++; $display("FAIL rnd_block@%0d: stalled %0d cycles exp <= %0d", n, run, SMAX);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 64; i++) begin
            total++; if (mem[i] !== ref_mem[i]) begin
                bad++; $display("FAIL rnd_mem%0d: got %h exp %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_cpu_fill();
        test_dma_write();
        test_contention();
        test_preempt();
        test_dma_read();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
